// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
//   8N1 UART receiver with 16x oversampling and 3-sample majority voting.
//   The serial line is double-synchronized. An edge detector on the
//   synchronized line starts a frame. Each bit spans 16 oversample ticks, and
//   the bit value is the majority of the samples taken at counts 7, 8 and 9.
//   The frame is decided at sample 9 of the stop bit, so back-to-back frames
//   are accepted even when the transmitter clock is slightly fast.
//
// Ports
//   Clk        in   1  system clock (50 MHz)
//   Rst        in   1  asynchronous active-high reset
//   Rs232_Rx   in   1  asynchronous serial input, idles high
//   baud_set   in   3  0=9600 1=19200 2=38400 3=57600 4=115200 others=9600
//   data_byte  out  8  last received byte (held until the next frame)
//   Rx_Done    out  1  one-cycle pulse when a frame completes
//   frame_err  out  1  stop bit of the last frame was sampled low
//   uart_state out  1  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_rx (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rs232_Rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       frame_err,
    output logic       uart_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        rx_s1;
    logic        rx_s2;
    logic        rx_s3;      // previous synchronized value, used only for edge detect
    logic        fall;

    logic [15:0] bps_dr;
    logic [15:0] div_cnt;
    logic        tick;

    logic [3:0]  smp_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        smp7;
    logic        smp8;
    logic        vote;

    // Divider terminal count for a 16x tick at 50 MHz.
    function automatic logic [15:0] bps_lookup(input logic [2:0] sel);
        case (sel)
            3'd1:    bps_lookup = 16'd161;
            3'd2:    bps_lookup = 16'd80;
            3'd3:    bps_lookup = 16'd53;
            3'd4:    bps_lookup = 16'd26;
            default: bps_lookup = 16'd324;
        endcase
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        majority3 = (a & b) | (a & c) | (b & c);
    endfunction

    always_comb begin
        fall       = rx_s3 & ~rx_s2;
        tick       = (state != IDLE) && (div_cnt == bps_dr);
        // Samples 7 and 8 are registered; sample 9 is the live synchronized value.
        vote       = majority3(smp7, smp8, rx_s2);
        uart_state = (state != IDLE);
    end

    // ---------------- input synchronizer ----------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= Rs232_Rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // ---------------- FSM state register ----------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fall) state_next = START;
            end
            START: begin
                // A start bit that votes high is line noise: abandon quietly.
                if (tick && smp_cnt == 4'd9 && vote)
                    state_next = IDLE;
                else if (tick && smp_cnt == 4'd15)
                    state_next = DATA;
            end
            DATA: begin
                if (tick && smp_cnt == 4'd15 && bit_cnt == 3'd7)
                    state_next = STOP;
            end
            STOP: begin
                if (tick && smp_cnt == 4'd9)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- baud divider and sample counting ----------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bps_dr  <= 16'd324;
            div_cnt <= 16'd0;
            smp_cnt <= 4'd0;
            bit_cnt <= 3'd0;
            smp7    <= 1'b1;
            smp8    <= 1'b1;
        end else begin
            // Rate is frozen for the whole frame once we leave IDLE.
            if (state == IDLE)
                bps_dr <= bps_lookup(baud_set);

            if (state == IDLE || tick) div_cnt <= 16'd0;
            else                       div_cnt <= div_cnt + 16'd1;

            if (state == IDLE) smp_cnt <= 4'd0;
            else if (tick)     smp_cnt <= smp_cnt + 4'd1;

            if (state == IDLE)
                bit_cnt <= 3'd0;
            else if (state == DATA && tick && smp_cnt == 4'd15)
                bit_cnt <= bit_cnt + 3'd1;

            if (tick && smp_cnt == 4'd7) smp7 <= rx_s2;
            if (tick && smp_cnt == 4'd8) smp8 <= rx_s2;
        end
    end

    // ---------------- shift register and outputs ----------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shift_reg <= 8'h00;
            data_byte <= 8'h00;
            frame_err <= 1'b0;
            Rx_Done   <= 1'b0;
        end else begin
            Rx_Done <= 1'b0;
            // LSB arrives first, so shift in from the top.
            if (state == DATA && tick && smp_cnt == 4'd9)
                shift_reg <= {vote, shift_reg[7:1]};
            if (state == STOP && tick && smp_cnt == 4'd9) begin
                data_byte <= shift_reg;
                frame_err <= ~vote;
                Rx_Done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

    localparam int BIT0 = 16 * 325;   // bit period in clocks at baud_set=0
    localparam int BIT4 = 16 * 27;    // bit period in clocks at baud_set=4
    localparam int TICK0 = 325;       // one oversample tick at baud_set=0

    logic       Clk;
    logic       Rst;
    logic       Rs232_Rx;
    logic [2:0] baud_set;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic       frame_err;
    logic       uart_state;

    int checks;
    int errors;
    int done_cnt;
    logic prev_done;
    logic [8:0] exp_q[$];   // {frame_err, data_byte}

    uart_byte_rx dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Rs232_Rx   (Rs232_Rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Scoreboard: every Rx_Done pulse pops one expected frame.
    always @(posedge Clk) begin
        logic [8:0] e;
        #1;
        if (Rx_Done) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL rx_done_width: Rx_Done high for 2+ cycles, required 1");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: Rx_Done with data_byte=%02h and no frame expected", data_byte);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (data_byte !== e[7:0]) begin
                    errors++;
                    $display("FAIL data_byte: got %02h expected %02h", data_byte, e[7:0]);
                end
                checks++;
                if (frame_err !== e[8]) begin
                    errors++;
                    $display("FAIL frame_err: got %b expected %b (byte %02h)", frame_err, e[8], e[7:0]);
                end
                checks++;
                if (uart_state !== 1'b0) begin
                    errors++;
                    $display("FAIL uart_state_at_done: got %b expected 0", uart_state);
                end
            end
        end
        prev_done = Rx_Done;
    end

    task automatic drive_bit(input logic v, input int cyc);
        Rs232_Rx = v;
        repeat (cyc) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int cyc, input bit expect_done);
        if (expect_done) exp_q.push_back({~stop, b});
        drive_bit(1'b0, cyc);
        for (int i = 0; i < 8; i++) drive_bit(b[i], cyc);
        drive_bit(stop, cyc);
        Rs232_Rx = 1'b1;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        Rs232_Rx = 1'b1;
        baud_set = 3'd0;
        repeat (5) @(negedge Clk);
        checks++;
        if ({data_byte, Rx_Done, frame_err, uart_state} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: data_byte=%02h Rx_Done=%b frame_err=%b uart_state=%b, required 00 0 0 0",
                     data_byte, Rx_Done, frame_err, uart_state);
        end
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        checks++;
        if (uart_state !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL idle_after_reset: uart_state=%b done_cnt=%0d, required 0 0", uart_state, done_cnt);
        end
    endtask

    // 0x55 at 9600 while baud_set jumps to 115200 mid-frame.
    task automatic test_single_and_baud_change;
        int d0;
        d0 = done_cnt;
        fork
            send_frame(8'h55, 1'b1, BIT0, 1'b1);
            begin
                repeat (BIT0 * 4 + BIT0 / 2) @(negedge Clk);
                checks++;
                if (uart_state !== 1'b1) begin
                    errors++;
                    $display("FAIL uart_state_busy: got %b expected 1", uart_state);
                end
                baud_set = 3'd4;
            end
        join
        checks++;
        if (done_cnt - d0 != 1 || data_byte !== 8'h55 || frame_err !== 1'b0 || uart_state !== 1'b0) begin
            errors++;
            $display("FAIL single_9600: pulses=%0d byte=%02h ferr=%b state=%b, required 1 55 0 0",
                     done_cnt - d0, data_byte, frame_err, uart_state);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        d0 = done_cnt;
        send_frame(8'hA3, 1'b1, BIT4, 1'b1);
        send_frame(8'h00, 1'b1, BIT4, 1'b1);
        send_frame(8'hFF, 1'b1, BIT4, 1'b1);
        repeat (BIT4) @(negedge Clk);
        checks++;
        if (done_cnt - d0 != 3 || data_byte !== 8'hFF || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: pulses=%0d last=%02h ferr=%b, required 3 ff 0",
                     done_cnt - d0, data_byte, frame_err);
        end
    endtask

    task automatic test_frame_error;
        int d0;
        d0 = done_cnt;
        send_frame(8'h81, 1'b0, BIT4, 1'b1);
        drive_bit(1'b1, BIT4 * 2);
        checks++;
        if (done_cnt - d0 != 1 || data_byte !== 8'h81 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL frame_error: pulses=%0d byte=%02h ferr=%b, required 1 81 1",
                     done_cnt - d0, data_byte, frame_err);
        end
    endtask

    // Glitch at 9600, then a good frame at 115200 that also clears frame_err.
    task automatic test_false_start;
        int d0;
        d0 = done_cnt;
        baud_set = 3'd0;
        repeat (4) @(negedge Clk);
        drive_bit(1'b0, 3 * TICK0);
        checks++;
        if (uart_state !== 1'b1) begin
            errors++;
            $display("FAIL false_start_busy: uart_state=%b expected 1", uart_state);
        end
        drive_bit(1'b1, 12 * TICK0);
        checks++;
        if (uart_state !== 1'b0 || done_cnt != d0 || data_byte !== 8'h81 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL false_start: state=%b pulses=%0d byte=%02h ferr=%b, required 0 0 81 1",
                     uart_state, done_cnt - d0, data_byte, frame_err);
        end
        baud_set = 3'd4;
        repeat (4) @(negedge Clk);
        send_frame(8'h3C, 1'b1, BIT4, 1'b1);
        checks++;
        if (done_cnt - d0 != 1 || data_byte !== 8'h3C || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL after_false_start: pulses=%0d byte=%02h ferr=%b, required 1 3c 0",
                     done_cnt - d0, data_byte, frame_err);
        end
    endtask

    task automatic test_reset_mid_frame;
        int d0;
        logic [7:0] b;
        d0 = done_cnt;
        b = 8'h5A;
        drive_bit(1'b0, BIT4);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT4);
        drive_bit(b[4], BIT4 / 2);
        #5;
        Rst = 1'b1;
        #1;
        checks++;
        if ({data_byte, Rx_Done, frame_err, uart_state} !== 11'h000) begin
            errors++;
            $display("FAIL async_reset: data_byte=%02h Rx_Done=%b frame_err=%b uart_state=%b, required 00 0 0 0",
                     data_byte, Rx_Done, frame_err, uart_state);
        end
        Rs232_Rx = 1'b1;
        repeat (10) @(negedge Clk);
        Rst = 1'b0;
        repeat (BIT4 * 2) @(negedge Clk);
        checks++;
        if (done_cnt != d0 || uart_state !== 1'b0 || data_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_abort: pulses=%0d state=%b byte=%02h, required 0 0 00",
                     done_cnt - d0, uart_state, data_byte);
        end
        send_frame(8'h12, 1'b1, BIT4, 1'b1);
        checks++;
        if (done_cnt - d0 != 1 || data_byte !== 8'h12 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame: pulses=%0d byte=%02h ferr=%b, required 1 12 0",
                     done_cnt - d0, data_byte, frame_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_cnt = 0;
        prev_done = 1'b0;
        Rst = 1'b1;
        Rs232_Rx = 1'b1;
        baud_set = 3'd0;
        @(negedge Clk);
        test_reset();
        test_single_and_baud_change();
        test_back_to_back();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
        repeat (BIT4) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames never received, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
